// File: rtl/regfile_mrp_pkg.sv
// Processor constants shared by the register file and the decoder.
// REG_ZERO names the architectural zero register; rd_src_e names the
// three possible sources of a read-port value, in priority order.
package regfile_mrp_pkg;

   // Architectural index of the hardwired zero register
   localparam int REG_ZERO = 0;

   // Source chosen for one read port
   typedef enum logic [1:0] {
      SRC_MEM    = 2'd0,
      SRC_BYPASS = 2'd1,
      SRC_ZERO   = 2'd2
   } rd_src_e;

   // Resolve read source priority: zero register beats bypass beats storage
   function automatic rd_src_e pick_src(input logic zero_hit, input logic byp_hit);
      rd_src_e src;
      if (zero_hit) begin
         src = SRC_ZERO;
      end else if (byp_hit) begin
         src = SRC_BYPASS;
      end else begin
         src = SRC_MEM;
      end
      return src;
   endfunction

endpackage

// File: rtl/regfile_mrp_rd_port_mux.sv
// One read port of the register file: DEPTH-to-1 selector over the storage
// array with zero-register and write-bypass override. Purely combinational;
// the top level registers the result.
module rd_port_mux
   import regfile_mrp_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 32,
   parameter int ADDR_W   = $clog2(DEPTH),
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic [DEPTH*WIDTH-1:0] mem_flat,
   input  logic [ADDR_W-1:0]      rd_addr,
   input  logic                   we,
   input  logic [ADDR_W-1:0]      wr_addr,
   input  logic [WIDTH-1:0]       wr_data,
   output logic [WIDTH-1:0]       sel_data
);

   logic [WIDTH-1:0] entry_s [DEPTH];
   logic             zero_hit_s;
   logic             byp_hit_s;
   rd_src_e          src_s;

   // Unpack the flat storage bus into addressable entries
   for (genvar i = 0; i < DEPTH; i++) begin : g_unpack
      assign entry_s[i] = mem_flat[i*WIDTH +: WIDTH];
   end

   // Detect zero-register and same-cycle write hits for this port's address
   always_comb begin
      zero_hit_s = 1'b0;
      byp_hit_s  = 1'b0;
      if (ZERO_REG == 1) begin
         zero_hit_s = (rd_addr == ADDR_W'(REG_ZERO));
      end else begin
         zero_hit_s = 1'b0;
      end
      if (BYPASS == 1) begin
         byp_hit_s = we && (wr_addr == rd_addr);
      end else begin
         byp_hit_s = 1'b0;
      end
   end

   // Select the port value according to the resolved source
   always_comb begin
      src_s    = pick_src(zero_hit_s, byp_hit_s);
      sel_data = {WIDTH{1'b0}};
      case (src_s)
         SRC_ZERO:   sel_data = {WIDTH{1'b0}};
         SRC_BYPASS: sel_data = wr_data;
         SRC_MEM:    sel_data = entry_s[rd_addr];
         default:    sel_data = {WIDTH{1'b0}};
      endcase
   end

endmodule

// File: rtl/regfile_mrp.sv
// Multi-read-port register file: DEPTH x WIDTH storage, one synchronous
// write port, NUM_RD registered read ports with optional write bypass and
// optional hardwired zero register. Reset clears storage and read outputs
// asynchronously so rd_valid drops the moment rst_n falls.
module regfile_mrp
   import regfile_mrp_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 32,
   parameter int ADDR_W   = $clog2(DEPTH),
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     we,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic [NUM_RD-1:0]        rd_en,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*WIDTH-1:0]  rd_data,
   output logic [NUM_RD-1:0]        rd_valid
);

   logic [WIDTH-1:0]        mem_r [DEPTH];
   logic [DEPTH*WIDTH-1:0]  mem_flat_s;
   logic                    wr_ok_s;
   logic [NUM_RD*WIDTH-1:0] sel_data_s;
   logic [NUM_RD*WIDTH-1:0] rd_data_r;
   logic [NUM_RD-1:0]       rd_valid_r;

   // Qualify the write: writes aimed at the hardwired zero register are dropped
   always_comb begin
      wr_ok_s = 1'b0;
      if (we && !((ZERO_REG == 1) && (wr_addr == ADDR_W'(REG_ZERO)))) begin
         wr_ok_s = 1'b1;
      end else begin
         wr_ok_s = 1'b0;
      end
   end

   // Storage array: cleared on reset, one entry updated per accepted write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {WIDTH{1'b0}};
         end
      end else if (wr_ok_s) begin
         mem_r[wr_addr] <= wr_data;
      end
   end

   // Present the storage as a flat bus for the per-port selectors
   for (genvar i = 0; i < DEPTH; i++) begin : g_flat
      assign mem_flat_s[i*WIDTH +: WIDTH] = mem_r[i];
   end

   // One selector per read port; ports are fully independent
   for (genvar p = 0; p < NUM_RD; p++) begin : g_port
      rd_port_mux #(
         .WIDTH    (WIDTH),
         .DEPTH    (DEPTH),
         .ADDR_W   (ADDR_W),
         .ZERO_REG (ZERO_REG),
         .BYPASS   (BYPASS)
      ) u_mux (
         .mem_flat (mem_flat_s),
         .rd_addr  (rd_addr[p*ADDR_W +: ADDR_W]),
         .we       (we),
         .wr_addr  (wr_addr),
         .wr_data  (wr_data),
         .sel_data (sel_data_s[p*WIDTH +: WIDTH])
      );
   end

   // Read output registers: data updates only on an enabled read, valid tracks rd_en
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_r  <= {(NUM_RD*WIDTH){1'b0}};
         rd_valid_r <= {NUM_RD{1'b0}};
      end else begin
         for (int p = 0; p < NUM_RD; p++) begin
            if (rd_en[p]) begin
               rd_data_r[p*WIDTH +: WIDTH] <= sel_data_s[p*WIDTH +: WIDTH];
            end
            rd_valid_r[p] <= rd_en[p];
         end
      end
   end

   assign rd_data  = rd_data_r;
   assign rd_valid = rd_valid_r;

endmodule

// File: tb/tb_regfile_mrp.sv
// Scoreboard bench for regfile_mrp. Two instances share one stimulus stream:
// dut_a uses ZERO_REG=1/BYPASS=1, dut_b uses ZERO_REG=0/BYPASS=0. Each read
// issued pushes hand-computed expected data per instance; a monitor pops and
// compares whenever rd_valid is seen.
module tb_regfile_mrp;

   localparam int W  = 32;
   localparam int D  = 32;
   localparam int AW = 5;
   localparam int NR = 2;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          we    = 1'b0;
   logic [AW-1:0] wr_addr = 5'd0;
   logic [W-1:0]  wr_data = 32'h0;
   logic [NR-1:0] rd_en   = 2'b00;
   logic [NR*AW-1:0] rd_addr = 10'd0;
   logic [NR*W-1:0]  rd_data_a, rd_data_b;
   logic [NR-1:0]    rd_valid_a, rd_valid_b;

   typedef struct {
      int          port;
      logic [W-1:0] data;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];
   exp_t e_a, e_b;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   regfile_mrp #(.WIDTH(W), .DEPTH(D), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a));

   regfile_mrp #(.WIDTH(W), .DEPTH(D), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(0), .BYPASS(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b));

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d);
      we      = 1'b1;
      wr_addr = a;
      wr_data = d;
   endtask

   task automatic rd(input int p, input logic [AW-1:0] a);
      rd_en[p]            = 1'b1;
      rd_addr[p*AW +: AW] = a;
   endtask

   // Push expectations for enabled ports, clock once, return at the next negedge
   task automatic step(input logic [W-1:0] ea0, input logic [W-1:0] ea1,
                       input logic [W-1:0] eb0, input logic [W-1:0] eb1);
      exp_t t;
      if (rd_en[0]) begin
         t.port = 0; t.data = ea0; q_a.push_back(t);
         t.data = eb0; q_b.push_back(t);
      end
      if (rd_en[1]) begin
         t.port = 1; t.data = ea1; q_a.push_back(t);
         t.data = eb1; q_b.push_back(t);
      end
      @(negedge clk);
      we    = 1'b0;
      rd_en = 2'b00;
   endtask

   function automatic logic [W-1:0] sweep_val(input int i);
      return W'(i) * 32'h01010101;
   endfunction

   // Monitor: compare every valid read result against the scoreboard
   always @(negedge clk) begin
      if (rst_n) begin
         for (int p = 0; p < NR; p++) begin
            if (rd_valid_a[p]) begin
               checks++;
               if (q_a.size() == 0) begin
                  errors++;
                  $display("FAIL dut_a port%0d: got unexpected valid data %h expected no read", p, rd_data_a[p*W +: W]);
               end else begin
                  e_a = q_a.pop_front();
                  if (e_a.port != p || rd_data_a[p*W +: W] !== e_a.data) begin
                     errors++;
                     $display("FAIL dut_a port%0d: got %h expected %h (port %0d)", p, rd_data_a[p*W +: W], e_a.data, e_a.port);
                  end
               end
            end
            if (rd_valid_b[p]) begin
               checks++;
               if (q_b.size() == 0) begin
                  errors++;
                  $display("FAIL dut_b port%0d: got unexpected valid data %h expected no read", p, rd_data_b[p*W +: W]);
               end else begin
                  e_b = q_b.pop_front();
                  if (e_b.port != p || rd_data_b[p*W +: W] !== e_b.data) begin
                     errors++;
                     $display("FAIL dut_b port%0d: got %h expected %h (port %0d)", p, rd_data_b[p*W +: W], e_b.data, e_b.port);
                  end
               end
            end
         end
      end
   end

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      chk("reset rd_valid_a", W'(rd_valid_a), 32'h0);
      chk("reset rd_valid_b", W'(rd_valid_b), 32'h0);
      chk("reset rd_data_a0", rd_data_a[31:0], 32'h0);
      chk("reset rd_data_b1", rd_data_b[63:32], 32'h0);
      rst_n = 1'b1;

      // Write then read on both ports
      wr(5'd7, 32'h12345678); step(32'h0, 32'h0, 32'h0, 32'h0);
      rd(0, 5'd7); rd(1, 5'd7);
      step(32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678);
      chk("wr-rd rd_valid_a", W'(rd_valid_a), 32'h3);
      chk("wr-rd rd_valid_b", W'(rd_valid_b), 32'h3);

      // Bypass collision: dut_a forwards new data, dut_b returns old
      wr(5'd9, 32'h00000001); step(32'h0, 32'h0, 32'h0, 32'h0);
      wr(5'd9, 32'hAAAA5555); rd(0, 5'd9); rd(1, 5'd7);
      step(32'hAAAA5555, 32'h12345678, 32'h00000001, 32'h12345678);
      rd(0, 5'd9); rd(1, 5'd9);
      step(32'hAAAA5555, 32'hAAAA5555, 32'hAAAA5555, 32'hAAAA5555);

      // Zero register, with simultaneous read then a plain read
      wr(5'd0, 32'hFFFFFFFF); rd(0, 5'd0);
      step(32'h0, 32'h0, 32'h0, 32'h0);
      rd(0, 5'd0); rd(1, 5'd0);
      step(32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF);

      // Hold: rd_data stays while rd_en low, even as the register is rewritten
      wr(5'd3, 32'h00000055); step(32'h0, 32'h0, 32'h0, 32'h0);
      rd(0, 5'd3); step(32'h55, 32'h0, 32'h55, 32'h0);
      for (int k = 0; k < 3; k++) begin
         if (k == 0) wr(5'd3, 32'h00000066);
         step(32'h0, 32'h0, 32'h0, 32'h0);
         chk("hold rd_data_a0", rd_data_a[31:0], 32'h55);
         chk("hold rd_data_b0", rd_data_b[31:0], 32'h55);
         chk("hold rd_valid_a", W'(rd_valid_a), 32'h0);
         chk("hold rd_valid_b", W'(rd_valid_b), 32'h0);
      end
      rd(0, 5'd3); step(32'h66, 32'h0, 32'h66, 32'h0);

      // Sweep: fill every register, read all addresses on both ports rotated
      for (int i = 0; i < D; i++) begin
         wr(AW'(i), sweep_val(i)); step(32'h0, 32'h0, 32'h0, 32'h0);
      end
      for (int i = 0; i < D; i++) begin
         rd(0, AW'(i)); rd(1, AW'((i + 16) % D));
         step(sweep_val(i), sweep_val((i + 16) % D), sweep_val(i), sweep_val((i + 16) % D));
      end

      // Reset mid-stream drops the in-flight result immediately
      wr(5'd5, 32'hDEADBEEF); step(32'h0, 32'h0, 32'h0, 32'h0);
      rd(0, 5'd5); rd(1, 5'd5);
      step(32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
      rd(0, 5'd5); rd(1, 5'd5);
      @(posedge clk); #1;
      chk("pre-reset rd_valid_a", W'(rd_valid_a), 32'h3);
      rst_n = 1'b0;
      #1;
      chk("async reset rd_valid_a", W'(rd_valid_a), 32'h0);
      chk("async reset rd_valid_b", W'(rd_valid_b), 32'h0);
      chk("async reset rd_data_a0", rd_data_a[31:0], 32'h0);
      chk("async reset rd_data_b1", rd_data_b[63:32], 32'h0);
      @(negedge clk);
      rd_en = 2'b00;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      rd(0, 5'd5); rd(1, 5'd5);
      step(32'h0, 32'h0, 32'h0, 32'h0);

      @(posedge clk); #1;
      chk("queue a drained", W'(q_a.size()), 32'h0);
      chk("queue b drained", W'(q_b.size()), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/regfile_mrp.md
# regfile_mrp

Parametrised multi-read-port register file generalising the 32-to-1 selector into a stateful storage block: DEPTH registers of WIDTH bits, one synchronous write port, NUM_RD independent registered read ports with write-to-read bypass and an optional hardwired zero register. It serves as the datapath register file of the processor core, feeding the decode/execute pipeline register with operands.

## Interface
- WIDTH, 32, data width of each register
- DEPTH, 32, number of registers (power of two, 2..64)
- ADDR_W, $clog2(DEPTH), address width
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes
- BYPASS, 1, 1 = same-cycle write data forwarded to matching reads

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- we  in  1  write enable
- wr_addr  in  ADDR_W  write address
- wr_data  in  WIDTH  write data
- rd_en  in  NUM_RD  per-port read enable
- rd_addr  in  NUM_RD*ADDR_W  read addresses, port p at [p*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*WIDTH  registered read data, port p at [p*WIDTH +: WIDTH]
- rd_valid  out  NUM_RD  per-port: rd_data updated by a read accepted last cycle

## Operation
- Reset (rst_n low, asynchronous): all DEPTH registers, all rd_data and rd_valid cleared to 0; held while rst_n low.
- Write: on rising clk with we=1, mem[wr_addr] <= wr_data; exception: ZERO_REG=1 and wr_addr=0 -> write discarded.
- Read, port p: on rising clk with rd_en[p]=1, rd_data[p] <= selected value; rd_valid[p] <= 1. With rd_en[p]=0, rd_data[p] holds previous value, rd_valid[p] <= 0.
- Selected value, priority order:
  1. ZERO_REG=1 and rd_addr[p]=0 -> 0 (overrides bypass).
  2. BYPASS=1, we=1, wr_addr=rd_addr[p] -> wr_data (new value).
  3. otherwise mem[rd_addr[p]] (pre-edge contents; BYPASS=0 gives old value on collision).
- Ports fully independent; any number may read the same address in the same cycle, all see identical data.
- Addresses always in range (DEPTH power of two); no error path.

## Timing
- Write latency: 1 cycle; a read issued the cycle after a write sees the written value regardless of BYPASS.
- Read latency: 1 cycle from rd_en/rd_addr sample to rd_data/rd_valid.
- Throughput: one write plus NUM_RD reads every cycle, no stalls, no back-pressure.
- rst_n deassertion: first write/read accepted on the first rising clk with rst_n high; reads before any write return 0.
- Reset asserted mid-operation: in-flight read result lost, rd_valid forced 0 immediately (not at the next edge).
- rd_data never changes except at a rising clk with rd_en[p]=1, or at reset.

## Structure
- Shared package: none required beyond the existing processor constants package; add REG_ZERO = 0 there for the decoder's use.
- Sub-module: rd_port_mux (parametrised DEPTH-to-1 WIDTH-bit selector plus zero/bypass priority logic), instantiated NUM_RD times in a generate loop; top level owns storage, write logic and the output registers.

## Test plan
- Reset: drive rst_n=0 mid-stream after writing 0xDEADBEEF to r5 -> rd_data=0, rd_valid=0 immediately; after release, read r5 -> 0x00000000.
- Write then read: write 0x12345678 to r7, next cycle read r7 on port 0 and r7 on port 1 -> both 0x12345678 one cycle later, rd_valid=2'b11.
- Bypass: r9=0x1 stored; same cycle write 0xAAAA5555 to r9 and read r9 -> BYPASS=1 returns 0xAAAA5555; BYPASS=0 build returns 0x00000001.
- Zero register: write 0xFFFFFFFF to r0, with and without simultaneous read of r0 -> always 0; ZERO_REG=0 build returns 0xFFFFFFFF next read.
- Hold: read r3=0x55 with rd_en=1, then rd_en=0 for 3 cycles while r3 rewritten to 0x66 -> rd_data stays 0x55, rd_valid=0.
- Sweep: write r[i]=i*0x01010101 for all i, read DEPTH addresses on all ports in rotating order (WIDTH=16, DEPTH=16, NUM_RD=4 build too) -> every read matches model.
